// File: rtl/axis_fifo_burst_reader_if.sv
// Signal bundle between the sample FIFO read port, the burst reader and the downstream stream consumer.
// The reader owns the master view; the FIFO/consumer environment owns the slave view.
interface axis_fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1,
    parameter int FIFO_LEN   = 8
);
    localparam int LEVEL_WIDTH = $clog2(FIFO_LEN);

    logic [DATA_WIDTH-1:0]  s_fifo_tdata;
    logic [USER_WIDTH-1:0]  s_fifo_tuser;
    logic                   s_fifo_tvalid;
    logic [LEVEL_WIDTH-1:0] s_fifo_tlevel;
    logic                   s_fifo_tempty;
    logic                   s_fifo_tready;

    logic [DATA_WIDTH-1:0]  m_axis_out_tdata;
    logic [USER_WIDTH-1:0]  m_axis_out_tuser;
    logic                   m_axis_out_tvalid;
    logic                   m_axis_out_tlast;
    logic                   m_axis_out_tready;

    modport master (
        input  s_fifo_tdata, s_fifo_tuser, s_fifo_tvalid, s_fifo_tlevel, s_fifo_tempty,
        output s_fifo_tready,
        output m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tvalid, m_axis_out_tlast,
        input  m_axis_out_tready
    );

    modport slave (
        output s_fifo_tdata, s_fifo_tuser, s_fifo_tvalid, s_fifo_tlevel, s_fifo_tempty,
        input  s_fifo_tready,
        input  m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tvalid, m_axis_out_tlast,
        output m_axis_out_tready
    );
endinterface

// File: rtl/axis_fifo_burst_reader.sv
// Pulls fixed-size bursts from a registered-flag FIFO once enough samples are stored and
// re-streams them through a 2-entry skid buffer with tlast on the final beat of each burst.
module axis_fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1,
    parameter int FIFO_LEN   = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    axis_fifo_burst_reader_if.master bus,
    output logic [15:0]              bursts_o,
    output logic                     err_o
);
    localparam int CNT_WIDTH  = $clog2(FIFO_LEN) + 1;
    localparam int WORD_WIDTH = DATA_WIDTH + USER_WIDTH;
    localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  req_left_q, req_left_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic                  hold_q, hold_d;
    logic [15:0]           bursts_q, bursts_d;
    logic                  err_q, err_d;
    logic [WORD_WIDTH-1:0] skid_q [2];
    logic [WORD_WIDTH-1:0] skid_d [2];

    logic [CNT_WIDTH-1:0]  avail;
    logic [WORD_WIDTH-1:0] in_word;
    logic                  out_valid, last_beat, pop, push, tlast_pop, space_ok, rd_req;

    // A level of 0 with the empty flag clear means the FIFO has wrapped to completely full.
    always_comb begin
        if (bus.s_fifo_tempty) begin
            avail = '0;
        end else if (bus.s_fifo_tlevel == '0) begin
            avail = CNT_WIDTH'(FIFO_LEN);
        end else begin
            avail = CNT_WIDTH'(bus.s_fifo_tlevel);
        end
    end

    assign in_word   = {bus.s_fifo_tuser, bus.s_fifo_tdata};
    assign out_valid = (occ_q != 2'd0);
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign pop       = out_valid && bus.m_axis_out_tready;
    assign push      = bus.s_fifo_tvalid && inflight_q;
    assign tlast_pop = pop && last_beat;

    // The beat leaving this cycle frees its slot, so a steady stream runs without bubbles
    // while a completely full skid never issues a request.
    assign space_ok = (occ_q == 2'd0) || ((occ_q == 2'd1) && (!inflight_q || pop));
    assign rd_req   = (state_q == READ) && (req_left_q > CNT_WIDTH'(inflight_q)) && space_ok;

    always_comb begin
        state_d    = state_q;
        req_left_d = req_left_q;
        beat_cnt_d = beat_cnt_q;
        hold_d     = hold_q;
        occ_d      = occ_q;
        skid_d[0]  = skid_q[0];
        skid_d[1]  = skid_q[1];
        bursts_d   = bursts_q;
        err_d      = err_q;
        inflight_d = rd_req;

        // Covers both a missing response and an unsolicited one.
        if (inflight_q != bus.s_fifo_tvalid) begin
            err_d = 1'b1;
        end
        if (push && (req_left_q != '0)) begin
            req_left_d = req_left_q - CNT_ONE;
        end
        if (pop) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
        end
        if (tlast_pop) begin
            bursts_d = bursts_q + 16'd1;
        end

        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    skid_d[0] = in_word;
                    occ_d     = 2'd1;
                end else if (occ_q == 2'd1) begin
                    skid_d[1] = in_word;
                    occ_d     = 2'd2;
                end else begin
                    err_d = 1'b1;
                end
            end
            2'b01: begin
                skid_d[0] = skid_q[1];
                occ_d     = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    skid_d[0] = in_word;
                end else begin
                    skid_d[0] = skid_q[1];
                    skid_d[1] = in_word;
                end
            end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (avail >= BURST_CNT) begin
                    state_d    = READ;
                    req_left_d = BURST_CNT;
                    beat_cnt_d = '0;
                end
            end
            READ: begin
                // With a free-running consumer the last beat can leave before DRAIN is reached.
                if (tlast_pop) begin
                    state_d = HOLD;
                    hold_d  = 1'b0;
                end else if ((req_left_q == '0) && !inflight_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tlast_pop) begin
                    state_d = HOLD;
                    hold_d  = 1'b0;
                end
            end
            HOLD: begin
                if (hold_q) begin
                    state_d = IDLE;
                    hold_d  = 1'b0;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            req_left_q <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            hold_q     <= 1'b0;
            bursts_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_left_q <= req_left_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            hold_q     <= hold_d;
            bursts_q   <= bursts_d;
            err_q      <= err_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_skid
        always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
                skid_q[gi] <= '0;
            end else begin
                skid_q[gi] <= skid_d[gi];
            end
        end
    end

    assign bus.s_fifo_tready     = rd_req;
    assign bus.m_axis_out_tdata  = skid_q[0][DATA_WIDTH-1:0];
    assign bus.m_axis_out_tuser  = skid_q[0][WORD_WIDTH-1:DATA_WIDTH];
    assign bus.m_axis_out_tvalid = out_valid;
    assign bus.m_axis_out_tlast  = out_valid && last_beat;
    assign bursts_o              = bursts_q;
    assign err_o                 = err_q;
endmodule

// File: tb/tb_axis_fifo_burst_reader.sv
// Bench for the burst reader: a behavioural registered-flag FIFO feeds the DUT and a scoreboard
// checks every output beat, plus a second instance with BURST_LEN equal to the FIFO depth.
module tb_axis_fifo_burst_reader;
    localparam int DW  = 16;
    localparam int UW  = 1;
    localparam int FL  = 8;
    localparam int BL  = 4;
    localparam int BL2 = 8;
    localparam int LW  = $clog2(FL);

    typedef logic [UW+DW-1:0] word_t;
    typedef logic [UW+DW:0]   exp_t;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [15:0] bursts, bursts2;
    logic        err, err2;

    always #5 clk_i = ~clk_i;

    axis_fifo_burst_reader_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_LEN(FL)) bus ();
    axis_fifo_burst_reader_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_LEN(FL)) bus2 ();

    axis_fifo_burst_reader #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_LEN(FL), .BURST_LEN(BL)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .bus(bus), .bursts_o(bursts), .err_o(err)
    );
    axis_fifo_burst_reader #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_LEN(FL), .BURST_LEN(BL2)) dut2 (
        .clk_i(clk_i), .reset_ni(reset_ni), .bus(bus2), .bursts_o(bursts2), .err_o(err2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural FIFO: reads answered one cycle after tready, flags registered.
    word_t stage_q[$], fq[$], stage2_q[$], fq2[$];
    exp_t  exp_q[$], exp2_q[$];
    int    drop_req = 0, drop_done = 0;

    always @(posedge clk_i) begin
        if (!reset_ni) begin
            fq.delete();
            bus.s_fifo_tvalid <= 1'b0;
            bus.s_fifo_tdata  <= '0;
            bus.s_fifo_tuser  <= '0;
            bus.s_fifo_tlevel <= '0;
            bus.s_fifo_tempty <= 1'b1;
        end else begin
            word_t w;
            if (bus.s_fifo_tready && fq.size() > 0 && drop_req > drop_done) begin
                drop_done++;
                bus.s_fifo_tvalid <= 1'b0;
            end else if (bus.s_fifo_tready && fq.size() > 0) begin
                w = fq.pop_front();
                {bus.s_fifo_tuser, bus.s_fifo_tdata} <= w;
                bus.s_fifo_tvalid <= 1'b1;
            end else begin
                bus.s_fifo_tvalid <= 1'b0;
            end
            while (stage_q.size() > 0) fq.push_back(stage_q.pop_front());
            bus.s_fifo_tlevel <= LW'(fq.size());
            bus.s_fifo_tempty <= (fq.size() == 0);
        end
    end

    always @(posedge clk_i) begin
        if (!reset_ni) begin
            fq2.delete();
            bus2.s_fifo_tvalid <= 1'b0;
            bus2.s_fifo_tdata  <= '0;
            bus2.s_fifo_tuser  <= '0;
            bus2.s_fifo_tlevel <= '0;
            bus2.s_fifo_tempty <= 1'b1;
        end else begin
            word_t w2;
            if (bus2.s_fifo_tready && fq2.size() > 0) begin
                w2 = fq2.pop_front();
                {bus2.s_fifo_tuser, bus2.s_fifo_tdata} <= w2;
                bus2.s_fifo_tvalid <= 1'b1;
            end else begin
                bus2.s_fifo_tvalid <= 1'b0;
            end
            while (stage2_q.size() > 0) fq2.push_back(stage2_q.pop_front());
            bus2.s_fifo_tlevel <= LW'(fq2.size());
            bus2.s_fifo_tempty <= (fq2.size() == 0);
        end
    end

    // Downstream ready: constant high, or the 1,0,0,1 repeating pattern.
    logic toggle_mode = 1'b0;
    int   rdy_idx = 0;
    always @(posedge clk_i) begin
        #1;
        if (toggle_mode) begin
            bus.m_axis_out_tready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
            rdy_idx++;
        end else begin
            bus.m_axis_out_tready = 1'b1;
        end
    end
    assign bus2.m_axis_out_tready = 1'b1;

    int    occ_m = 0, xfer_cnt = 0, rdreq_cnt = 0;
    logic  stall_prev = 1'b0;
    logic [UW+DW+1:0] stall_word;
    exp_t  exp_w, exp_w2;

    always @(negedge clk_i) begin
        if (reset_ni) begin
            if (stall_prev)
                check_val("stall_hold", 32'({bus.m_axis_out_tvalid, bus.m_axis_out_tlast,
                          bus.m_axis_out_tuser, bus.m_axis_out_tdata}), 32'(stall_word));
            if (occ_m == 2)
                check_val("rdy_when_skid_full", 32'(bus.s_fifo_tready), 32'd0);
            if (bus.m_axis_out_tvalid && bus.m_axis_out_tready) begin
                xfer_cnt++;
                check_val("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check_val("beat", 32'({bus.m_axis_out_tlast, bus.m_axis_out_tuser,
                              bus.m_axis_out_tdata}), 32'(exp_w));
                end
                $display("beat %0d: data=%0d user=%0d last=%0d", xfer_cnt,
                         bus.m_axis_out_tdata, bus.m_axis_out_tuser, bus.m_axis_out_tlast);
            end
            if (bus.s_fifo_tready) rdreq_cnt++;
            stall_prev = bus.m_axis_out_tvalid && !bus.m_axis_out_tready;
            stall_word = {bus.m_axis_out_tvalid, bus.m_axis_out_tlast,
                          bus.m_axis_out_tuser, bus.m_axis_out_tdata};
            occ_m = occ_m + int'(bus.s_fifo_tvalid)
                  - int'(bus.m_axis_out_tvalid && bus.m_axis_out_tready);
        end
    end

    always @(negedge clk_i) begin
        if (reset_ni && bus2.m_axis_out_tvalid && bus2.m_axis_out_tready) begin
            check_val("b8_beat_expected", 32'(exp2_q.size() > 0), 32'd1);
            if (exp2_q.size() > 0) begin
                exp_w2 = exp2_q.pop_front();
                check_val("b8_beat", 32'({bus2.m_axis_out_tlast, bus2.m_axis_out_tuser,
                          bus2.m_axis_out_tdata}), 32'(exp_w2));
            end
            $display("b8 beat: data=%0d last=%0d", bus2.m_axis_out_tdata, bus2.m_axis_out_tlast);
        end
    end

    int wr_idx = 0;

    task automatic push_samples(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] d;
            logic          u;
            d = DW'(first + i);
            u = d[0];
            stage_q.push_back({u, d});
            exp_q.push_back({1'((wr_idx % BL) == BL - 1), u, d});
            wr_idx++;
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || stage_q.size() != 0) && t < 400) begin
            @(negedge clk_i);
            t++;
        end
        check_val({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (8) @(negedge clk_i);
    endtask

    task automatic measure_latency(input string tag);
        int t0, t;
        @(negedge clk_i);
        t0 = cyc;
        t  = 0;
        while (!bus.m_axis_out_tvalid && t < 30) begin
            @(negedge clk_i);
            t++;
        end
        check_val(tag, 32'(cyc - t0), 32'd3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_fifo_tready"}, 32'(bus.s_fifo_tready), 32'd0);
        check_val({tag, "_tvalid"}, 32'(bus.m_axis_out_tvalid), 32'd0);
        check_val({tag, "_tlast"}, 32'(bus.m_axis_out_tlast), 32'd0);
        check_val({tag, "_tdata"}, 32'(bus.m_axis_out_tdata), 32'd0);
        check_val({tag, "_tuser"}, 32'(bus.m_axis_out_tuser), 32'd0);
        check_val({tag, "_bursts"}, 32'(bursts), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        reset_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        reset_ni = 1'b1;

        // Second instance: a full FIFO of 8 drained as one 8-beat burst.
        for (int i = 0; i < 8; i++) begin
            stage2_q.push_back({1'b0, DW'(101 + i)});
            exp2_q.push_back({1'(i == BL2 - 1), 1'b0, DW'(101 + i)});
        end

        // Two bursts from 8 samples written at once.
        push_samples(8, 1);
        wait_drain("t1");
        check_val("t1_bursts", 32'(bursts), 32'd2);
        check_val("t1_err", 32'(err), 32'd0);
        check_val("b8_remaining", 32'(exp2_q.size()), 32'd0);
        check_val("b8_bursts", 32'(bursts2), 32'd1);
        check_val("b8_err", 32'(err2), 32'd0);

        // Three samples must not start a burst; the fourth does.
        base = rdreq_cnt;
        push_samples(3, 11);
        repeat (20) @(negedge clk_i);
        check_val("t2_no_request", 32'(rdreq_cnt - base), 32'd0);
        push_samples(1, 14);
        measure_latency("t2_latency");
        wait_drain("t2");
        check_val("t2_bursts", 32'(bursts), 32'd3);

        // Full FIFO reports level 0 with empty clear.
        push_samples(8, 21);
        measure_latency("t3_full_latency");
        wait_drain("t3");
        check_val("t3_bursts", 32'(bursts), 32'd5);

        // Downstream back-pressure pattern.
        toggle_mode = 1'b1;
        push_samples(8, 31);
        wait_drain("t4");
        toggle_mode = 1'b0;
        check_val("t4_bursts", 32'(bursts), 32'd7);
        check_val("t4_err", 32'(err), 32'd0);

        // One missing FIFO response.
        drop_req++;
        push_samples(4, 41);
        wait_drain("t5");
        check_val("t5_err", 32'(err), 32'd1);
        check_val("t5_bursts", 32'(bursts), 32'd8);
        repeat (5) @(negedge clk_i);
        check_val("t5_err_sticky", 32'(err), 32'd1);

        // Reset after the second beat of a burst.
        base = xfer_cnt;
        push_samples(4, 51);
        t = 0;
        while (xfer_cnt < base + 2 && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check_val("t6_two_beats", 32'(xfer_cnt >= base + 2), 32'd1);
        @(posedge clk_i);
        #1 reset_ni = 1'b0;
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        exp_q.delete();
        stage_q.delete();
        occ_m      = 0;
        stall_prev = 1'b0;
        wr_idx     = 0;
        @(negedge clk_i);
        check_reset_outputs("t6_after_reset");
        base = rdreq_cnt;
        repeat (10) @(negedge clk_i);
        check_val("t6_idle_no_request", 32'(rdreq_cnt - base), 32'd0);
        push_samples(4, 61);
        wait_drain("t6");
        check_val("t6_bursts", 32'(bursts), 32'd1);
        check_val("t6_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
